booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one `modified_booth_algorithm_4bit` multiplier between `NUM_REQ` independent requesters. It accepts one operand pair at a time and drives the multiplier's operand/valid inputs. It captures the product and returns it to the granted requester with a ready/valid handshake. It sits between requester-side logic (AXI-lite shims, test sequencers) and the single multiplier instance; only one multiplication is in flight at any time.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IN_W`, 5: operand width (two's complement), matches multiplier input.
- `OUT_W`, 10: product width, equals `2*IN_W`.
- `TIMEOUT_CYC`, 64: WAIT-state watchdog limit in cycles; used only with the macro.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand-pair valid.
- `req_a`, `req_b`  in  NUM_REQ*IN_W each  packed operands; slice i belongs to requester i.
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse.
- `rsp_valid`  out  NUM_REQ  one-hot response valid.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_data`  out  OUT_W  product, shared by all requesters and qualified by `rsp_valid`.
- `rsp_err`  out  1  response is a timeout, not a product. Tied 0 without the macro.
- `mba_a`, `mba_b`  out  IN_W each  multiplier operands.
- `mba_val`  out  1  multiplier start strobe.
- `mba_out`  in  OUT_W  multiplier product.
- `mba_out_val`  in  1  multiplier product valid.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, pick the first set bit starting at `rr_ptr` and wrapping modulo `NUM_REQ`.
  - Assert `req_ready[g]` combinationally in the same cycle. The handshake completes in that cycle.
  - Latch `req_a[g]`, `req_b[g]` and `g`, then go to ISSUE.
- **ISSUE**
  - `mba_val`=1 for exactly one cycle, with `mba_a`/`mba_b` driven from the latches.
  - Go to WAIT.
- **WAIT**
  - On `mba_out_val`=1, register `mba_out` into `rsp_data` and go to RESP.
  - `mba_out_val` is ignored in IDLE, ISSUE and RESP. A multiplier that raises it in the same cycle as `mba_val` is unsupported.
- **RESP**
  - `rsp_valid[g]`=1, with `rsp_data`/`rsp_err` held stable.
  - On `rsp_ready[g]`=1, set `rr_ptr` to (g+1) mod `NUM_REQ` and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- **Arbiter behaviour**
  - `req_ready` is 0 in every state except IDLE. Requesters must hold `req_valid` and operands stable until accepted.
  - No arithmetic is done in this block. Operands and product pass through bit-exact, with signedness as the multiplier defines it.
  - Fairness: a continuously requesting requester is granted within `NUM_REQ` transactions.
- **Reset** (reset=0 at a rising edge, any state)
  - State=IDLE, `rr_ptr`=0, `grant_id`=0, `rsp_data`=0, `rsp_err`=0, operand latches=0, watchdog=0.
  - All outputs are 0: `req_ready`, `rsp_valid`, `mba_val`, `mba_a`, `mba_b`, `busy`.
  - An in-flight multiplication is abandoned and its late `mba_out_val` is ignored, since the FSM is in IDLE. The multiplier shares the same `reset`.

## Timing
- Accept at cycle T, `mba_val` at T+1, WAIT from T+2.
- If the multiplier asserts `mba_out_val` at T+1+L, then `rsp_valid` is asserted at T+2+L.
- Minimum turnaround: the next accept is possible in the cycle after the `rsp_valid`&`rsp_ready` handshake.
- `busy` is registered from state and asserted in ISSUE, WAIT and RESP.

## Configuration
- `BOOTH_ARB_WATCHDOG_EN` defined:
  - A WAIT-state counter is cleared on entry to WAIT.
  - If `mba_out_val` has not arrived after `TIMEOUT_CYC` cycles in WAIT, go to RESP with `rsp_data`=all ones and `rsp_err`=1.
  - In that case `rr_ptr` advances normally.
- `BOOTH_ARB_WATCHDOG_EN` undefined:
  - No counter. WAIT persists until `mba_out_val`, and `rsp_err` is constant 0.

## Structure
- Shared package `booth_arb_pkg`:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - `BOOTH_IN_W`=5, `BOOTH_OUT_W`=10 constants.
  - Default `TIMEOUT_CYC`.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant plus its index and a found flag.

## Test plan
- Reset, then requester 2 sends A=5'b00011 (3), B=5'b11110 (-2).
  - Expect `req_ready[2]` in the same cycle and one `mba_val` pulse with those operands.
  - Expect `rsp_valid[2]` with `rsp_data`=10'h3FA (-6) and `rsp_err`=0.
- All four requesters valid continuously:
  - Grant order is 0,1,2,3,0,1.
  - `grant_id` matches each grant and `rsp_valid` is one-hot to the matching requester.
- `rsp_ready[g]` held low for 5 cycles in RESP:
  - `rsp_valid`/`rsp_data` stay stable.
  - No `req_ready` and no `mba_val` occur until acceptance.
  - `rsp_ready` of a non-granted requester is ignored.
- Reset pulled low during WAIT:
  - All outputs are 0 the next cycle and `rr_ptr`=0.
  - A later `mba_out_val` produces no `rsp_valid`.
- With `BOOTH_ARB_WATCHDOG_EN`, `TIMEOUT_CYC`=8, and the multiplier model never asserting `mba_out_val`:
  - `rsp_valid[g]` with `rsp_data`=10'h3FF and `rsp_err`=1, with RESP entered on WAIT cycle 8.
  - Without the macro, `busy` stays high indefinitely.
- Multiplier model with latency L=3, and requester 1 valid in the cycle after the previous handshake:
  - Accept-to-`rsp_valid` is exactly 5 cycles.
  - Back-to-back grants occur with no idle bubble beyond the single IDLE cycle.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// ---------------------------------------------------------------------------
// booth_arb_pkg
//   Shared definitions for the booth multiplier arbiter:
//   - BOOTH_IN_W / BOOTH_OUT_W : operand and product widths of the shared
//                                modified_booth_algorithm_4bit multiplier
//   - DEFAULT_TIMEOUT_CYC      : default WAIT-state watchdog limit
//   - arb_state_e              : sequencer state encoding
// ---------------------------------------------------------------------------
package booth_arb_pkg;

  localparam int BOOTH_IN_W          = 5;
  localparam int BOOTH_OUT_W         = 10;
  localparam int DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/booth_mult_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req starting at index ptr and
//   wrapping modulo NUM_REQ; the first set bit wins.
//   Ports:
//     req   in  NUM_REQ  request vector
//     ptr   in  ID_W     index with highest priority (must be < NUM_REQ)
//     grant out NUM_REQ  one-hot grant (all zero when nothing requests)
//     idx   out ID_W     index of the granted bit
//     found out 1        at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  localparam int SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + SW'(off);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
//   Shares one modified_booth_algorithm_4bit multiplier between NUM_REQ
//   requesters. One operand pair is accepted at a time (round-robin), issued
//   to the multiplier with a single-cycle mba_val strobe, and the product is
//   returned to the granted requester with a ready/valid handshake.
//
//   Optional feature macro: BOOTH_ARB_WATCHDOG_EN
//     defined   : WAIT gives up after TIMEOUT_CYC cycles and returns
//                 rsp_data = all ones with rsp_err = 1
//     undefined : WAIT persists until mba_out_val; rsp_err is constant 0
//
//   Ports:
//     clock        in   rising-edge clock
//     reset        in   synchronous active-low reset
//     req_valid    in   [NUM_REQ]        operand pair valid per requester
//     req_a, req_b in   [NUM_REQ*IN_W]   packed operands, slice i = requester i
//     req_ready    out  [NUM_REQ]        one-hot acceptance (IDLE only)
//     rsp_valid    out  [NUM_REQ]        one-hot response valid
//     rsp_ready    in   [NUM_REQ]        response accept per requester
//     rsp_data     out  [OUT_W]          product (or all ones on timeout)
//     rsp_err      out  1                response is a timeout
//     mba_a, mba_b out  [IN_W]           multiplier operands
//     mba_val      out  1                multiplier start strobe
//     mba_out      in   [OUT_W]          multiplier product
//     mba_out_val  in   1                multiplier product valid
//     busy         out  1                not in IDLE
//     grant_id     out  [ID_W]           current / last granted requester
// ---------------------------------------------------------------------------
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IN_W        = BOOTH_IN_W,
  parameter int OUT_W       = BOOTH_OUT_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_a,
  input  logic [NUM_REQ*IN_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic [IN_W-1:0]         mba_a,
  output logic [IN_W-1:0]         mba_b,
  output logic                    mba_val,
  input  logic [OUT_W-1:0]        mba_out,
  input  logic                    mba_out_val,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  arb_state_e          state;
  arb_state_e          next_state;
  logic [ID_W-1:0]     rr_ptr;
  logic [IN_W-1:0]     a_q;
  logic [IN_W-1:0]     b_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_found;
  logic                accept;
  logic                rsp_done;
  logic                wd_fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The acceptance handshake completes combinationally in IDLE. It is masked
  // while reset is held so no requester sees a handshake the FSM discards.
  assign accept    = (state == ST_IDLE) && reset && pick_found;
  assign req_ready = accept ? pick_grant : '0;

  // Only the granted requester's rsp_ready can close the response.
  assign rsp_done  = (state == ST_RESP) && rsp_ready[grant_id];

  assign rsp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign mba_val   = (state == ST_ISSUE);
  assign mba_a     = a_q;
  assign mba_b     = b_q;

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (pick_found)            next_state = ST_ISSUE;
      ST_ISSUE:                            next_state = ST_WAIT;
      ST_WAIT:  if (mba_out_val || wd_fire) next_state = ST_RESP;
      ST_RESP:  if (rsp_done)              next_state = ST_IDLE;
      default:                             next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of the
  // order the statements are written in.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      grant_id <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_data <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_IDLE);

      if (accept) begin
        grant_id <= pick_idx;
        a_q      <= req_a[pick_idx*IN_W +: IN_W];
        b_q      <= req_b[pick_idx*IN_W +: IN_W];
      end

      // A product arriving in the same cycle as the timeout still wins.
      if (state == ST_WAIT) begin
        if (mba_out_val) begin
          rsp_data <= mba_out;
        end else if (wd_fire) begin
          rsp_data <= '1;
        end
      end

      if (rsp_done) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

`ifdef BOOTH_ARB_WATCHDOG_EN
  // Counter holds (WAIT cycle number - 1); it is cleared while in ISSUE so it
  // reads 0 on the first WAIT cycle.
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            rsp_err_q;

  assign wd_fire = (state == ST_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (state == ST_WAIT) begin
        if (mba_out_val) begin
          rsp_err_q <= 1'b0;
        end else if (wd_fire) begin
          rsp_err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_arbiter
//   Directed bench for booth_mult_arbiter with a behavioural multiplier of
//   programmable latency and a scoreboard of expected responses.
// ---------------------------------------------------------------------------
module tb_booth_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IN_W    = 5;
  localparam int OUT_W   = 10;
  localparam int TMO     = 8;

  logic                    clock;
  logic                    reset;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*IN_W-1:0] req_a;
  logic [NUM_REQ*IN_W-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ready;
  logic [OUT_W-1:0]        rsp_data;
  logic                    rsp_err;
  logic [IN_W-1:0]         mba_a;
  logic [IN_W-1:0]         mba_b;
  logic                    mba_val;
  logic [OUT_W-1:0]        mba_out = '0;
  logic                    mba_out_val = 1'b0;
  logic                    busy;
  logic [1:0]              grant_id;

  booth_mult_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mba_a       (mba_a),
    .mba_b       (mba_b),
    .mba_val     (mba_val),
    .mba_out     (mba_out),
    .mba_out_val (mba_out_val),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Signed 5x5 -> 10-bit reference product.
  function automatic logic [OUT_W-1:0] ref_mul(logic [IN_W-1:0] a, logic [IN_W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[OUT_W-1:0];
  endfunction

  // Multiplier model: mba_out_val rises lat cycles after the mba_val cycle.
  // It deliberately ignores reset so a late product can follow a DUT reset.
  int               lat      = 1;
  bit               model_en = 1'b1;
  int               pend_cnt = 0;
  bit               pend     = 1'b0;
  logic [OUT_W-1:0] pend_prod = '0;

  always @(posedge clock) begin
    mba_out_val <= 1'b0;
    if (mba_val && model_en) begin
      if (lat <= 1) begin
        mba_out_val <= 1'b1;
        mba_out     <= ref_mul(mba_a, mba_b);
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= lat - 1;
        pend_prod <= ref_mul(mba_a, mba_b);
      end
    end else if (pend) begin
      if (pend_cnt == 1) begin
        mba_out_val <= 1'b1;
        mba_out     <= pend_prod;
        pend        <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  typedef struct {
    int               id;
    logic [OUT_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];

  int               checks = 0;
  int               errors = 0;
  int               acc_time;
  int               rsp_time;
  logic [OUT_W-1:0] last_data;
  logic             last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every step starts 1 time unit after a rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int id, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    req_valid[id]        = 1'b1;
    req_a[id*IN_W +: IN_W] = a;
    req_b[id*IN_W +: IN_W] = b;
  endtask

  // Waits for the acceptance pulse, checks it targets exp_id and pushes the
  // expected product. Returns 1 time unit into the ISSUE cycle.
  task automatic wait_accept(input int exp_id);
    bit ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        check("accept_onehot", 32'(req_ready), 32'(1) << exp_id);
        sb.push_back('{exp_id,
                       ref_mul(req_a[exp_id*IN_W +: IN_W], req_b[exp_id*IN_W +: IN_W]),
                       1'b0});
        acc_time = cycle_cnt;
      end
      cyc();
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Waits for a response, compares it against the scoreboard head and
  // completes the handshake. Returns 1 time unit into the following cycle.
  task automatic wait_resp();
    bit   ok = 1'b0;
    exp_t e;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (rsp_valid != '0) begin
        ok = 1'b1;
        rsp_time  = cycle_cnt;
        last_data = rsp_data;
        last_err  = rsp_err;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_onehot", 32'(rsp_valid), 32'(1) << e.id);
          check("rsp_data",   32'(rsp_data),  32'(e.data));
          check("rsp_err",    32'(rsp_err),   32'(e.err));
          check("rsp_grant",  32'(grant_id),  32'(e.id));
          rsp_ready[e.id] = 1'b1;
        end
      end
      cyc();
    end
    rsp_ready = '0;
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    bit ok;
    bit bad;
    bit saw_late;
    int set_t;
    int r1;
    logic [OUT_W-1:0] hold_data;

    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    // ---- Reset state ----
    repeat (3) cyc();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mba_val",   32'(mba_val),   32'd0);
    check("rst_mba_a",     32'(mba_a),     32'd0);
    check("rst_mba_b",     32'(mba_b),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_grant_id",  32'(grant_id),  32'd0);
    reset = 1'b1;
    cyc();

    // ---- Single transaction: requester 2, 3 * -2 ----
    set_req(2, 5'b00011, 5'b11110);
    set_t = cycle_cnt;
    wait_accept(2);
    check("t1_same_cycle", 32'(acc_time), 32'(set_t));
    req_valid = '0;
    #1;
    check("t1_mba_val",  32'(mba_val),  32'd1);
    check("t1_mba_a",    32'(mba_a),    32'h03);
    check("t1_mba_b",    32'(mba_b),    32'h1E);
    check("t1_busy",     32'(busy),     32'd1);
    check("t1_grant_id", 32'(grant_id), 32'd2);
    cyc();
    #1;
    check("t1_single_pulse", 32'(mba_val), 32'd0);
    cyc();
    wait_resp();
    check("t1_data_const", 32'(last_data), 32'h3FA);
    check("t1_err_const",  32'(last_err),  32'd0);

    // ---- All four requesters continuously valid ----
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 3), 5'(28 + i));
    for (int k = 0; k < 6; k++) begin
      wait_accept(k % NUM_REQ);
      #1;
      check("t2_grant_id", 32'(grant_id), 32'(k % NUM_REQ));
      check("t2_mba_val",  32'(mba_val),  32'd1);
      cyc();
      wait_resp();
    end
    req_valid = '0;

    // ---- Response stall with a competing request pending ----
    set_req(3, 5'h09, 5'h0A);
    set_req(0, 5'h13, 5'h02);
    wait_accept(3);
    req_valid[3] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      #1;
      if (rsp_valid != '0) ok = 1'b1;
      else cyc();
    end
    check("t3_rsp_seen", 32'(ok), 32'd1);
    hold_data = rsp_data;
    check("t3_data_value", 32'(hold_data), 32'h05A);
    rsp_ready = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      check("t3_rsp_valid_hold", 32'(rsp_valid), 32'b1000);
      check("t3_rsp_data_hold",  32'(rsp_data),  32'(hold_data));
      check("t3_no_req_ready",   32'(req_ready), 32'd0);
      check("t3_no_mba_val",     32'(mba_val),   32'd0);
      cyc();
      #1;
    end
    wait_resp();
    wait_accept(0);
    req_valid[0] = 1'b0;
    wait_resp();

    // ---- Reset during WAIT, late product must be ignored ----
    lat = 6;
    set_req(1, 5'h07, 5'h05);
    wait_accept(1);
    req_valid = '0;
    cyc();
    cyc();
    #1;
    check("t4_busy_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    cyc();
    #1;
    check("t4_req_ready", 32'(req_ready), 32'd0);
    check("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4_mba_val",   32'(mba_val),   32'd0);
    check("t4_mba_a",     32'(mba_a),     32'd0);
    check("t4_mba_b",     32'(mba_b),     32'd0);
    check("t4_busy",      32'(busy),      32'd0);
    check("t4_rsp_data",  32'(rsp_data),  32'd0);
    check("t4_grant_id",  32'(grant_id),  32'd0);
    reset = 1'b1;
    sb.delete();
    bad      = 1'b0;
    saw_late = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      #1;
      if (mba_out_val) saw_late = 1'b1;
      if (rsp_valid != '0 || busy) bad = 1'b1;
    end
    check("t4_late_seen", 32'(saw_late), 32'd1);
    check("t4_no_rsp",    32'(bad),      32'd0);
    cyc();
    lat = 1;
    // rr_ptr back at 0: requester 0 must win over requester 3.
    set_req(3, 5'h1F, 5'h1F);
    set_req(0, 5'h0F, 5'h0F);
    wait_accept(0);
    req_valid[0] = 1'b0;
    wait_resp();
    wait_accept(3);
    req_valid[3] = 1'b0;
    wait_resp();

    // ---- Multiplier never answers ----
    model_en = 1'b0;
    set_req(0, 5'h05, 5'h06);
    wait_accept(0);
    req_valid = '0;
`ifdef BOOTH_ARB_WATCHDOG_EN
    void'(sb.pop_back());
    sb.push_back('{0, 10'h3FF, 1'b1});
    wait_resp();
    check("t5_wd_latency", 32'(rsp_time - acc_time), 32'(2 + TMO));
`else
    ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      cyc();
      #1;
      if (!busy || rsp_valid != '0) ok = 1'b0;
    end
    check("t5_busy_hold", 32'(ok), 32'd1);
    sb.delete();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
`endif
    model_en = 1'b1;

    // ---- Latency 3, back-to-back from requester 1 ----
    lat = 3;
    set_req(1, 5'h0F, 5'h10);
    wait_accept(1);
    req_valid = '0;
    wait_resp();
    r1 = rsp_time;
    check("t6_latency_a", 32'(rsp_time - acc_time), 32'd5);
    check("t6_data_a",    32'(last_data),           32'h310);
    set_req(1, 5'h10, 5'h10);
    wait_accept(1);
    check("t6_back_to_back", 32'(acc_time), 32'(r1 + 1));
    req_valid = '0;
    wait_resp();
    check("t6_latency_b", 32'(rsp_time - acc_time), 32'd5);
    check("t6_data_b",    32'(last_data),           32'h100);
    check("sb_drained",   32'(sb.size()),           32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
